// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 note decoder and its event FIFO.
//   parse_state_t  : scan-code parser states (make / break / extended).
//   PS2_BREAK/EXT  : set-2 prefix bytes.
//   PS2_UP/DOWN    : extended arrow codes used for octave shifting.
//   NUM_KEYS       : number of piano keys on the keyboard map.
//   note_event_t   : one queued event {note, on}.
//   note_number()  : octave*12 + key index, in 7 bits (max 96, never wraps).
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } parse_state_t;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_UP    = 8'h75;
  localparam logic [7:0] PS2_DOWN  = 8'h72;

  localparam int NUM_KEYS = 13;

  typedef struct packed {
    logic [6:0] note;
    logic       on;
  } note_event_t;

  function automatic logic [6:0] note_number(input logic [2:0] octave,
                                             input logic [3:0] key_idx);
    return 7'(octave) * 7'd12 + 7'(key_idx);
  endfunction

endpackage

// File: rtl/event_fifo.sv
// event_fifo: first-word fall-through FIFO for note events.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only;
//                the storage array is data and is not reset).
//   push/wdata : write request; accepted when not full, or when full and a
//                pop happens in the same cycle.
//   pop        : consume the head; ignored while empty.
//   rdata      : head entry, forced to zero while empty so the outputs have
//                a defined value straight out of reset.
//   full/empty : occupancy flags.
// DEPTH must be a power of two (2..16) so the pointers wrap naturally.
module event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees a slot, so a push at full still lands.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ps2_note_decoder.sv
// ps2_note_decoder: turns the PS/2 wrapper's set-2 scan-byte stream into
// piano note-on/note-off events.
//   Clock, btnCpuReset : clock, asynchronous active-low reset.
//   ScanData, Valid    : scan byte and its valid level; one byte per rising
//                        edge of Valid.
//   EventValid/Ready   : FWFT event queue handshake.
//   EventNote, EventOn : head event, note = octave*12 + key index.
//   HeldKeys           : bitmap of held piano keys (bit = key index).
//   Octave             : current octave.
//   Overflow           : sticky, set when an event is dropped at full queue.
// Optional feature: define PS2_OCTAVE_SHIFT_EN to let E0 75 / E0 72 (Up/Down)
// shift the octave while no key is held. Without it Octave is fixed at
// DEFAULT_OCTAVE and all extended makes are discarded.
module ps2_note_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int DEFAULT_OCTAVE = 4
) (
  input  logic                Clock,
  input  logic                btnCpuReset,
  input  logic [7:0]          ScanData,
  input  logic                Valid,
  output logic                EventValid,
  input  logic                EventReady,
  output logic [6:0]          EventNote,
  output logic                EventOn,
  output logic [NUM_KEYS-1:0] HeldKeys,
  output logic [2:0]          Octave,
  output logic                Overflow
);

  localparam logic [2:0] OCT_INIT = 3'(DEFAULT_OCTAVE);

  parse_state_t        state;
  logic                ValidQ;
  logic                strobe;
  logic                key_hit;
  logic [3:0]          key_idx;
  logic [NUM_KEYS-1:0] key_mask;
  logic                key_is_held;
  logic                push_on;
  logic                push_off;
  logic                ev_push;
  logic                ev_drop;
  note_event_t         ev_in;
  note_event_t         ev_head;
  logic                fifo_full;
  logic                fifo_empty;

  // Rising edge of Valid: a level held high yields one byte.
  assign strobe = Valid & ~ValidQ;

  // Piano key map: A W S E D F T G Y H U J K -> C .. C'.
  always_comb begin
    key_hit = 1'b1;
    key_idx = 4'd0;
    case (ScanData)
      8'h1C:   key_idx = 4'd0;
      8'h1D:   key_idx = 4'd1;
      8'h1B:   key_idx = 4'd2;
      8'h24:   key_idx = 4'd3;
      8'h23:   key_idx = 4'd4;
      8'h2B:   key_idx = 4'd5;
      8'h2C:   key_idx = 4'd6;
      8'h34:   key_idx = 4'd7;
      8'h35:   key_idx = 4'd8;
      8'h33:   key_idx = 4'd9;
      8'h3C:   key_idx = 4'd10;
      8'h3B:   key_idx = 4'd11;
      8'h42:   key_idx = 4'd12;
      default: key_hit = 1'b0;
    endcase
  end

  assign key_mask    = key_hit ? (NUM_KEYS'(1) << key_idx) : '0;
  assign key_is_held = |(HeldKeys & key_mask);

  // Prefix bytes never hit the key map, so no extra filtering is needed here.
  // A make of an already-held key is a typematic repeat; a break of a key
  // that is not held is an orphan. Neither produces an event.
  assign push_on  = strobe & (state == IDLE) & key_hit & ~key_is_held;
  assign push_off = strobe & (state == BRK)  & key_hit &  key_is_held;
  assign ev_push  = push_on | push_off;
  assign ev_in    = '{note: note_number(Octave, key_idx), on: push_on};

  // When full the only pop candidate is the head, so EventReady decides.
  assign ev_drop  = ev_push & fifo_full & ~EventReady;

  // ---- parse stage: FSM, held-key bitmap and overflow flag ----
  always_ff @(posedge Clock or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      state    <= IDLE;
      ValidQ   <= 1'b0;
      HeldKeys <= '0;
      Overflow <= 1'b0;
    end else begin
      ValidQ <= Valid;
      if (strobe) begin
        case (state)
          IDLE: begin
            if (ScanData == PS2_BREAK)    state <= BRK;
            else if (ScanData == PS2_EXT) state <= EXT;
            else                          state <= IDLE;
          end
          EXT:     state <= (ScanData == PS2_BREAK) ? EXT_BRK : IDLE;
          BRK:     state <= IDLE;
          EXT_BRK: state <= IDLE;
        endcase
      end
      // The bitmap follows the keyboard even when the event itself is dropped.
      if (push_on)       HeldKeys <= HeldKeys | key_mask;
      else if (push_off) HeldKeys <= HeldKeys & ~key_mask;
      if (ev_drop) Overflow <= 1'b1;
    end
  end

`ifdef PS2_OCTAVE_SHIFT_EN
  logic ext_make;

  assign ext_make = strobe & (state == EXT) & (ScanData != PS2_BREAK);

  // Shifting only with no keys held keeps every note-off at its note-on pitch.
  always_ff @(posedge Clock or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      Octave <= OCT_INIT;
    end else if (ext_make && (HeldKeys == '0)) begin
      if ((ScanData == PS2_UP) && (Octave != 3'd7))
        Octave <= Octave + 3'd1;
      else if ((ScanData == PS2_DOWN) && (Octave != 3'd0))
        Octave <= Octave - 3'd1;
    end
  end
`else
  assign Octave = OCT_INIT;
`endif

  // ---- event queue stage ----
  event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(note_event_t))
  ) u_event_fifo (
    .clk   (Clock),
    .rst_n (btnCpuReset),
    .push  (ev_push),
    .wdata (ev_in),
    .pop   (EventReady),
    .rdata (ev_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign EventValid = ~fifo_empty;
  assign EventNote  = ev_head.note;
  assign EventOn    = ev_head.on;

endmodule

// File: tb/tb_ps2_note_decoder.sv
// tb_ps2_note_decoder: directed and randomized scenarios for ps2_note_decoder
// against a queue-based behavioural model of the key/event rules.
module tb_ps2_note_decoder;

  localparam int DEPTH   = 4;
  localparam int DEF_OCT = 4;

  logic        Clock = 1'b0;
  logic        btnCpuReset = 1'b0;
  logic [7:0]  ScanData = 8'h00;
  logic        Valid = 1'b0;
  logic        EventReady = 1'b0;
  logic        EventValid;
  logic [6:0]  EventNote;
  logic        EventOn;
  logic [12:0] HeldKeys;
  logic [2:0]  Octave;
  logic        Overflow;

  ps2_note_decoder #(
    .FIFO_DEPTH     (DEPTH),
    .DEFAULT_OCTAVE (DEF_OCT)
  ) dut (
    .Clock       (Clock),
    .btnCpuReset (btnCpuReset),
    .ScanData    (ScanData),
    .Valid       (Valid),
    .EventValid  (EventValid),
    .EventReady  (EventReady),
    .EventNote   (EventNote),
    .EventOn     (EventOn),
    .HeldKeys    (HeldKeys),
    .Octave      (Octave),
    .Overflow    (Overflow)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int note;
    bit on;
  } ev_t;

  ev_t        mq[$];
  bit         m_held[13];
  int         m_oct;
  bit         m_ovf;
  bit         m_vq;
  bit         pend_brk;
  bit         pend_ext;
  logic [7:0] keys[13] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C,
                           8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42};
  int         n_checks = 0;
  int         n_pass = 0;

  function automatic int key_of(input logic [7:0] b);
    for (int i = 0; i < 13; i++) if (keys[i] == b) return i;
    return -1;
  endfunction

  function automatic logic [12:0] held_vec();
    logic [12:0] v;
    v = '0;
    for (int i = 0; i < 13; i++) v[i] = m_held[i];
    return v;
  endfunction

  task automatic m_push(input int note, input bit on);
    ev_t e;
    e.note = note;
    e.on   = on;
    if (mq.size() < DEPTH) mq.push_back(e);
    else m_ovf = 1'b1;
  endtask

  // Scan-code rules: F0 prefixes a break, E0 an extended code.
  task automatic model_byte(input logic [7:0] b);
    int k;
    k = key_of(b);
    if (pend_brk) begin
      if (!pend_ext && k >= 0 && m_held[k]) begin
        m_held[k] = 1'b0;
        m_push(m_oct * 12 + k, 1'b0);
      end
      pend_brk = 1'b0;
      pend_ext = 1'b0;
    end else if (pend_ext) begin
      if (b == 8'hF0) pend_brk = 1'b1;
      else begin
        pend_ext = 1'b0;
`ifdef PS2_OCTAVE_SHIFT_EN
        if (held_vec() == '0) begin
          if (b == 8'h75 && m_oct < 7) m_oct++;
          else if (b == 8'h72 && m_oct > 0) m_oct--;
        end
`endif
      end
    end else if (b == 8'hF0) pend_brk = 1'b1;
    else if (b == 8'hE0) pend_ext = 1'b1;
    else if (k >= 0 && !m_held[k]) begin
      m_held[k] = 1'b1;
      m_push(m_oct * 12 + k, 1'b1);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    foreach (m_held[i]) m_held[i] = 1'b0;
    m_oct = DEF_OCT;
    m_ovf = 1'b0;
    m_vq = 1'b0;
    pend_brk = 1'b0;
    pend_ext = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, then sample point #1 after edge.
  task automatic step(input logic v, input logic [7:0] b, input logic rdy);
    bit pop;
    bit stb;
    Valid = v;
    ScanData = b;
    EventReady = rdy;
    pop = rdy && (mq.size() > 0);
    stb = v && !m_vq;
    m_vq = v;
    if (pop) void'(mq.pop_front());
    if (stb) model_byte(b);
    @(posedge Clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic rdy);
    step(1'b1, b, rdy);
    step(1'b0, b, rdy);
  endtask

  task automatic do_reset();
    btnCpuReset = 1'b0;
    Valid = 1'b0;
    EventReady = 1'b0;
    ScanData = 8'h00;
    model_reset();
    repeat (2) @(posedge Clock);
    #1;
    btnCpuReset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (EventValid !== 1'b0) $display("FAIL reset_valid got %0b want 0", EventValid); else n_pass++;
    n_checks++; if (EventNote !== 7'd0) $display("FAIL reset_note got %0d want 0", EventNote); else n_pass++;
    n_checks++; if (EventOn !== 1'b0) $display("FAIL reset_on got %0b want 0", EventOn); else n_pass++;
    n_checks++; if (HeldKeys !== 13'd0) $display("FAIL reset_held got %h want 0", HeldKeys); else n_pass++;
    n_checks++; if (Octave !== 3'(DEF_OCT)) $display("FAIL reset_octave got %0d want %0d", Octave, DEF_OCT); else n_pass++;
    n_checks++; if (Overflow !== 1'b0) $display("FAIL reset_overflow got %0b want 0", Overflow); else n_pass++;
  endtask

  task automatic test_press_release();
    do_reset();
    step(1'b1, 8'h1C, 1'b1);
    n_checks++; if ({EventValid, EventNote, EventOn} !== {1'b1, 7'd48, 1'b1}) $display("FAIL press_event got v=%0b n=%0d on=%0b want v=1 n=48 on=1", EventValid, EventNote, EventOn); else n_pass++;
    n_checks++; if (HeldKeys !== 13'h0001) $display("FAIL press_held got %h want 0001", HeldKeys); else n_pass++;
    step(1'b0, 8'h1C, 1'b1);
    n_checks++; if (EventValid !== 1'b0) $display("FAIL press_popped got %0b want 0", EventValid); else n_pass++;
    send(8'hF0, 1'b1);
    step(1'b1, 8'h1C, 1'b1);
    n_checks++; if ({EventValid, EventNote, EventOn} !== {1'b1, 7'd48, 1'b0}) $display("FAIL release_event got v=%0b n=%0d on=%0b want v=1 n=48 on=0", EventValid, EventNote, EventOn); else n_pass++;
    n_checks++; if (HeldKeys !== 13'h0000) $display("FAIL release_held got %h want 0000", HeldKeys); else n_pass++;
    step(1'b0, 8'h1C, 1'b1);
  endtask

  task automatic test_typematic();
    do_reset();
    repeat (3) send(8'h42, 1'b0);
    n_checks++; if ({EventValid, EventNote, EventOn} !== {1'b1, 7'd60, 1'b1}) $display("FAIL repeat_first got v=%0b n=%0d on=%0b want v=1 n=60 on=1", EventValid, EventNote, EventOn); else n_pass++;
    step(1'b0, 8'h00, 1'b1);
    n_checks++; if (EventValid !== 1'b0) $display("FAIL repeat_single got %0b want 0", EventValid); else n_pass++;
    // F0 held high for 10 cycles is one prefix, so the next 42 is a break.
    repeat (10) step(1'b1, 8'hF0, 1'b1);
    step(1'b0, 8'hF0, 1'b1);
    step(1'b1, 8'h42, 1'b1);
    n_checks++; if ({EventValid, EventNote, EventOn} !== {1'b1, 7'd60, 1'b0}) $display("FAIL level_break got v=%0b n=%0d on=%0b want v=1 n=60 on=0", EventValid, EventNote, EventOn); else n_pass++;
    step(1'b0, 8'h42, 1'b1);
    do_reset();
    repeat (10) step(1'b1, 8'h42, 1'b0);
    step(1'b0, 8'h42, 1'b0);
    n_checks++; if ({EventValid, EventNote} !== {1'b1, 7'd60}) $display("FAIL level_make got v=%0b n=%0d want v=1 n=60", EventValid, EventNote); else n_pass++;
    step(1'b0, 8'h00, 1'b1);
    n_checks++; if (EventValid !== 1'b0) $display("FAIL level_single got %0b want 0", EventValid); else n_pass++;
  endtask

  task automatic test_unmapped();
    do_reset();
    send(8'hF0, 1'b0);
    send(8'h1D, 1'b0);
    send(8'h15, 1'b0);
    send(8'hE0, 1'b0);
    send(8'h1C, 1'b0);
    n_checks++; if (EventValid !== 1'b0) $display("FAIL unmapped_valid got %0b want 0", EventValid); else n_pass++;
    n_checks++; if (HeldKeys !== 13'h0000) $display("FAIL unmapped_held got %h want 0000", HeldKeys); else n_pass++;
    send(8'h1B, 1'b0);
    n_checks++; if ({EventValid, EventNote, EventOn} !== {1'b1, 7'd50, 1'b1}) $display("FAIL unmapped_idle got v=%0b n=%0d on=%0b want v=1 n=50 on=1", EventValid, EventNote, EventOn); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] five[5] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23};
    do_reset();
    for (int i = 0; i < 5; i++) send(five[i], 1'b0);
    n_checks++; if (Overflow !== 1'b1) $display("FAIL ovf_set got %0b want 1", Overflow); else n_pass++;
    n_checks++; if (HeldKeys !== 13'h001F) $display("FAIL ovf_held got %h want 001F", HeldKeys); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({EventValid, EventNote, EventOn} !== {1'b1, 7'(48 + i), 1'b1}) $display("FAIL ovf_drain%0d got v=%0b n=%0d want v=1 n=%0d", i, EventValid, EventNote, 48 + i); else n_pass++;
      step(1'b0, 8'h00, 1'b1);
    end
    n_checks++; if (EventValid !== 1'b0) $display("FAIL ovf_empty got %0b want 0", EventValid); else n_pass++;
    do_reset();
    for (int i = 0; i < 4; i++) send(five[i], 1'b0);
    n_checks++; if (Overflow !== 1'b0) $display("FAIL full_no_ovf got %0b want 0", Overflow); else n_pass++;
    step(1'b1, 8'h23, 1'b1);
    step(1'b0, 8'h23, 1'b0);
    n_checks++; if (Overflow !== 1'b0) $display("FAIL pushpop_ovf got %0b want 0", Overflow); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({EventValid, EventNote} !== {1'b1, 7'(49 + i)}) $display("FAIL pushpop_drain%0d got v=%0b n=%0d want v=1 n=%0d", i, EventValid, EventNote, 49 + i); else n_pass++;
      step(1'b0, 8'h00, 1'b1);
    end
  endtask

  task automatic test_octave();
    do_reset();
`ifdef PS2_OCTAVE_SHIFT_EN
    repeat (4) begin
      send(8'hE0, 1'b1);
      send(8'h75, 1'b1);
    end
    n_checks++; if (Octave !== 3'd7) $display("FAIL oct_up_sat got %0d want 7", Octave); else n_pass++;
    step(1'b1, 8'h1C, 1'b1);
    n_checks++; if ({EventValid, EventNote, EventOn} !== {1'b1, 7'd84, 1'b1}) $display("FAIL oct_note got v=%0b n=%0d want v=1 n=84", EventValid, EventNote); else n_pass++;
    step(1'b0, 8'h1C, 1'b1);
    send(8'hE0, 1'b1);
    send(8'h72, 1'b1);
    n_checks++; if (Octave !== 3'd7) $display("FAIL oct_held_lock got %0d want 7", Octave); else n_pass++;
    send(8'hF0, 1'b1);
    send(8'h1C, 1'b1);
    send(8'hE0, 1'b1);
    send(8'h72, 1'b1);
    n_checks++; if (Octave !== 3'd6) $display("FAIL oct_down got %0d want 6", Octave); else n_pass++;
`else
    send(8'hE0, 1'b1);
    send(8'h75, 1'b1);
    n_checks++; if (Octave !== 3'(DEF_OCT)) $display("FAIL oct_fixed got %0d want %0d", Octave, DEF_OCT); else n_pass++;
    n_checks++; if (EventValid !== 1'b0) $display("FAIL oct_no_event got %0b want 0", EventValid); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(8'h1C, 1'b0);
    send(8'h1D, 1'b0);
    send(8'hF0, 1'b0);
    n_checks++; if (EventValid !== 1'b1) $display("FAIL mid_queued got %0b want 1", EventValid); else n_pass++;
    btnCpuReset = 1'b0;
    #1;
    n_checks++; if ({EventValid, EventNote, EventOn, Overflow} !== 10'd0) $display("FAIL mid_reset_evt got v=%0b n=%0d on=%0b ovf=%0b want all 0", EventValid, EventNote, EventOn, Overflow); else n_pass++;
    n_checks++; if (HeldKeys !== 13'h0000) $display("FAIL mid_reset_held got %h want 0000", HeldKeys); else n_pass++;
    n_checks++; if (Octave !== 3'(DEF_OCT)) $display("FAIL mid_reset_oct got %0d want %0d", Octave, DEF_OCT); else n_pass++;
    model_reset();
    Valid = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    btnCpuReset = 1'b1;
    step(1'b1, 8'h1C, 1'b1);
    n_checks++; if ({EventValid, EventNote, EventOn} !== {1'b1, 7'd48, 1'b1}) $display("FAIL mid_after got v=%0b n=%0d on=%0b want v=1 n=48 on=1", EventValid, EventNote, EventOn); else n_pass++;
    step(1'b0, 8'h1C, 1'b1);
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic [7:0] extra[5] = '{8'hE0, 8'h75, 8'h72, 8'h15, 8'h42};
    int r;
    int hold;
    bit exp_v;
    for (int round = 0; round < 2; round++) begin
      do_reset();
      for (int it = 0; it < 250; it++) begin
        r = int'($urandom_range(0, 22));
        if (r < 13) b = keys[r];
        else if (r < 18) b = 8'hF0;
        else b = extra[r - 18];
        hold = int'($urandom_range(1, 3));
        for (int j = 0; j <= hold; j++) begin
          step(j < hold, b, 1'($urandom_range(0, 1)));
          exp_v = (mq.size() > 0);
          n_checks++; if (EventValid !== exp_v) $display("FAIL rand_valid it=%0d got %0b want %0b", it, EventValid, exp_v); else n_pass++;
          if (exp_v) begin
            n_checks++; if ({EventNote, EventOn} !== {7'(mq[0].note), mq[0].on}) $display("FAIL rand_head it=%0d got n=%0d on=%0b want n=%0d on=%0b", it, EventNote, EventOn, mq[0].note, mq[0].on); else n_pass++;
          end
          n_checks++; if (HeldKeys !== held_vec()) $display("FAIL rand_held it=%0d got %h want %h", it, HeldKeys, held_vec()); else n_pass++;
          n_checks++; if (Overflow !== m_ovf) $display("FAIL rand_ovf it=%0d got %0b want %0b", it, Overflow, m_ovf); else n_pass++;
          n_checks++; if (Octave !== 3'(m_oct)) $display("FAIL rand_oct it=%0d got %0d want %0d", it, Octave, m_oct); else n_pass++;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_press_release();
    test_typematic();
    test_unmapped();
    test_overflow();
    test_octave();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_note_decoder.md
# ps2_note_decoder

Downstream consumer of the PS/2 keyboard wrapper's scan-byte stream (`ScanData`/`Valid`, set-2 scan codes). It parses make, break (`F0`) and extended (`E0`) sequences. It maps 13 piano keys to MIDI-style note numbers, suppresses typematic repeats, and queues note-on/note-off events in a small FIFO for the player/tone stage.

## Interface
- `FIFO_DEPTH`, default 4: event FIFO entries; power of two, 2..16.
- `DEFAULT_OCTAVE`, default 4: octave loaded at reset; range 0..7.
- `Clock`  in  1  system clock, the same domain as the keyboard wrapper.
- `btnCpuReset`  in  1  reset, asynchronous and active-low.
- `ScanData`  in  8  scan byte from the keyboard wrapper.
- `Valid`  in  1  byte-valid level from the wrapper; one byte is accepted per rising edge.
- `EventValid`  out  1  FIFO head valid.
- `EventReady`  in  1  consumer accepts head.
- `EventNote`  out  7  note number at head: `octave*12 + key_index`.
- `EventOn`  out  1  1 = note-on, 0 = note-off.
- `HeldKeys`  out  13  bitmap of currently held piano keys; bit = key_index.
- `Octave`  out  3  current octave.
- `Overflow`  out  1  sticky flag, set when an event is dropped because the FIFO is full.

## Operation
- **Byte strobe.** `ValidQ` is a register of `Valid`. `strobe = Valid & ~ValidQ`. A level held on `Valid` yields exactly one byte.
- **Parser FSM:** `IDLE`, `BRK`, `EXT`, `EXT_BRK`.
  - `IDLE`: `F0` → `BRK`. `E0` → `EXT`. Any other byte is a make code; stay in `IDLE`.
  - `EXT`: `F0` → `EXT_BRK`. Any other byte is an extended make; → `IDLE`.
  - `BRK`: any byte is a break code; → `IDLE`.
  - `EXT_BRK`: any byte is an extended break (discarded); → `IDLE`.
- **Key map** (key_index 0..12): `1C` `1D` `1B` `24` `23` `2B` `2C` `34` `35` `33` `3C` `3B` `42` (A W S E D F T G Y H U J K = C..C').
  - Unmapped make/break codes are discarded with no event.
- **Make of mapped key:**
  - If its `HeldKeys` bit is 0: set the bit and push {note, On=1}.
  - If the bit is already 1 (typematic repeat): no event.
- **Break of mapped key:**
  - If its bit is 1: clear the bit and push {note, On=0}.
  - If the bit is 0: no event.
- **Note arithmetic:** `EventNote = Octave*12 + key_index`, computed in 7 bits. The maximum is 7*12+12 = 96, so it never wraps.
- **FIFO:** first-word fall-through.
  - Pop when `EventValid & EventReady`.
  - Push when full and no pop in the same cycle: the event is dropped, `HeldKeys` still updates, and `Overflow` is set.
  - Simultaneous push and pop when full: both occur; no overflow.
  - Pop when empty: ignored.
- **Reset values:** FSM = `IDLE`; `ValidQ`=0; FIFO empty; `EventValid`=0; `EventNote`=0; `EventOn`=0; `HeldKeys`=0; `Octave`=`DEFAULT_OCTAVE`; `Overflow`=0.
- **Reset mid-sequence** (e.g. after `F0`) discards the partial sequence. Held keys and queued events are lost.

## Timing
- Strobe in cycle N → FSM, `HeldKeys` and FIFO update at the end of cycle N.
  - If the FIFO was empty, `EventValid`=1 with the new entry from cycle N+1.
  - Latency from the `Valid` rising edge to `EventValid` is 1 cycle.
- `EventValid`, `EventNote` and `EventOn` are registered/FIFO outputs and hold stable until popped.
- Throughput: one byte per 2 cycles minimum, since `Valid` must fall between bytes. The FIFO sustains a pop every cycle.
- `HeldKeys` and `Octave` change in the same cycle as the corresponding FIFO push.

## Configuration
- **With `PS2_OCTAVE_SHIFT_EN` defined:**
  - Extended make `E0 75` (Up) increments `Octave`, saturating at 7.
  - Extended make `E0 72` (Down) decrements `Octave`, saturating at 0.
  - A shift is ignored while `HeldKeys != 0`, so every note-off matches its note-on.
  - No event is pushed for a shift.
- **Without the macro:** all extended makes are discarded and `Octave` is constant at `DEFAULT_OCTAVE`.

## Structure
- **Shared package `ps2_pkg`:**
  - Parser state enum.
  - `PS2_BREAK`=8'hF0 and `PS2_EXT`=8'hE0 constants.
  - `NUM_KEYS`=13.
  - Event struct {note[6:0], on}.
  - Arrow codes `PS2_UP`=8'h75 and `PS2_DOWN`=8'h72.
- **One sub-module, `event_fifo`:** parameterised-depth FWFT FIFO (`FIFO_DEPTH`, width 8) with full/empty outputs.
- The key-map lookup is a combinational case inside the top.

## Test plan
- **Press/release:** bytes `1C`, `F0 1C` with `EventReady`=1 → events {48, On=1} then {48, On=0}; `HeldKeys` bit 0 sets, then clears.
- **Typematic suppression and `Valid` level:**
  - `42` sent three times → exactly one {60, On=1}.
  - `Valid` held high for 10 cycles with `42` → still one event.
- **Unmapped and orphan codes:**
  - `F0 1D` without a prior make → no event.
  - `15` and `E0 1C` → no event.
  - FSM returns to `IDLE`: a following `1B` yields {50, On=1}.
- **FIFO overflow:**
  - With `EventReady`=0, press 5 distinct keys → 4 events queued and `Overflow`=1.
  - Drain → events in press order.
  - Simultaneous push and pop at full → no new overflow.
- **Octave shift (`PS2_OCTAVE_SHIFT_EN`):**
  - `E0 75` ×4 → `Octave`=7 (saturated); then `1C` → {84, On=1}.
  - `E0 72` while A is held → `Octave` unchanged.
- **Reset mid-sequence:**
  - Assert `btnCpuReset`=0 after `F0` with 2 events queued → all outputs at reset values.
  - After release, `1C` → {48, On=1}.
